// File: rtl/noc_pkg.sv
// Shared types for the mesh router input requester: flit codes, port ids,
// FSM encoding, timeout limit and the XY route helper.
package noc_pkg;

    localparam int COORD_W = 4;
    localparam int NPORTS  = 5;

    typedef enum logic [1:0] {
        FT_BODY   = 2'b00,
        FT_TAIL   = 2'b01,
        FT_HEAD   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic [2:0] {
        P_LOCAL = 3'd0,
        P_NORTH = 3'd1,
        P_EAST  = 3'd2,
        P_SOUTH = 3'd3,
        P_WEST  = 3'd4
    } port_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SEND = 2'd2
    } state_e;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

    // X dimension is resolved completely before Y is considered
    function automatic port_e xy_route(
        input logic [COORD_W-1:0] dx,
        input logic [COORD_W-1:0] dy,
        input logic [COORD_W-1:0] x_id,
        input logic [COORD_W-1:0] y_id
    );
        port_e p;
        p = P_LOCAL;
        unique case (1'b1)
            (dx > x_id):                p = P_EAST;
            (dx < x_id):                p = P_WEST;
            (dx == x_id && dy > y_id):  p = P_NORTH;
            (dx == x_id && dy < y_id):  p = P_SOUTH;
            default:                    p = P_LOCAL;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Small power-of-two flit FIFO with a combinational head-of-queue port.
// Head reads as zero while empty; a push is refused whenever the FIFO is full.
module flit_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, wr_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    always_comb begin
        wr_d  = do_push ? wr_q + 1'b1 : wr_q;
        rd_d  = do_pop ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/port_requester.sv
// Router input-port requester: buffers flits, XY-routes the head, holds a
// one-hot request until the tail leaves. Define PORT_REQ_TIMEOUT_EN for err.
module port_requester
    import noc_pkg::*;
#(
    parameter int                 DATA_W = 16,
    parameter int                 DEPTH  = 4,
    parameter logic [COORD_W-1:0] X_ID   = '0,
    parameter logic [COORD_W-1:0] Y_ID   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_flit,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [NPORTS-1:0] req,
    input  logic [NPORTS-1:0] gnt,
    output logic [DATA_W-1:0] out_flit,
    output logic              out_valid,
    output logic              err
);

    state_e            state_q;
    port_e             sel_q, sel_d;
    logic [NPORTS-1:0] req_q, req_d;
    logic [DATA_W-1:0] head;
    logic              full;
    logic              empty;
    logic              pop;
    logic              discard;
    logic              head_is_hdr;
    flit_type_e        head_type;

    flit_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (in_valid),
        .data_i  (in_flit),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign head_type   = flit_type_e'(head[DATA_W-1 -: 2]);
    assign head_is_hdr = head[DATA_W-1];
    assign sel_d       = xy_route(head[7:4], head[3:0], X_ID, Y_ID);
    assign req_d       = {{(NPORTS-1){1'b0}}, 1'b1} << sel_d;

    assign out_valid = (state_q == ST_REQ || state_q == ST_SEND)
                       && gnt[sel_q] && !empty;
    // Body/tail without a preceding head is dropped straight from the FIFO
    assign discard   = (state_q == ST_IDLE) && !empty && !head_is_hdr;
    assign pop       = out_valid || discard;

    assign in_ready = !full;
    assign out_flit = head;
    assign req      = req_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sel_q   <= P_LOCAL;
            req_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!empty && head_is_hdr) begin
                        sel_q   <= sel_d;
                        req_q   <= req_d;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (out_valid) begin
                        if (head_type == FT_SINGLE) begin
                            req_q   <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    if (out_valid && head_type == FT_TAIL) begin
                        req_q   <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    req_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PORT_REQ_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q != ST_REQ) begin
                cnt_q <= '0;
            end else begin
                if (cnt_q != TIMEOUT_LIMIT) begin
                    cnt_q <= cnt_q + 8'd1;
                end
                if (cnt_q == TIMEOUT_LIMIT && !gnt[sel_q]) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
